exc_ctrl: RTL and testbench

- Exception/interrupt initiator that drives the coprocessor-0 exception interface of the 54-instruction CPU.
- Collects syscall/break/teq trap indications from the decoder and external hardware interrupt lines, then arbitrates them.
- Issues a one-cycle exception pulse with cause code and faulting PC to CP0, and redirects fetch to the handler vector.
- Sequences the eret return through CP0's EPC.

---
 rtl/exc_ctrl_if.sv | 26 ++
 rtl/exc_ctrl.sv | 150 +++++++++++++++
 tb/tb_exc_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/exc_ctrl_if.sv
// Decoder / CP0 / fetch-side signal bundle for the exception initiator.
// exc_ctrl connects through the master modport; the environment uses slave.
interface exc_ctrl_if;
  logic [31:0] pc_in;
  logic        syscall;
  logic        brk;
  logic        teq_trap;
  logic        eret;
  logic [31:0] status;
  logic [31:0] epc;
  logic        exception;
  logic [4:0]  cause;
  logic [31:0] exc_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    input  pc_in, syscall, brk, teq_trap, eret, status, epc,
    output exception, cause, exc_pc, redirect, redirect_pc
  );

  modport slave (
    output pc_in, syscall, brk, teq_trap, eret, status, epc,
    input  exception, cause, exc_pc, redirect, redirect_pc
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt initiator: arbitrates traps and hw interrupts, pulses CP0, redirects fetch.
// Optional macro EXC_COUNT_EN builds the taken-exception counter; otherwise exc_count is tied to zero.
//
// state   | meaning
// IDLE    | normal execution; traps, interrupts and spurious eret accepted
// RAISE   | one-cycle exception pulse to CP0, fetch redirected to VECTOR
// HANDLER | handler running; interrupts blocked, traps still nest
// RETURN  | one-cycle redirect to CP0 EPC, back to IDLE
module exc_ctrl #(
  parameter logic [31:0] VECTOR      = 32'h0040_0004,
  parameter int          NUM_INT     = 4,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  exc_ctrl_if.master         bus,
  input  logic [NUM_INT-1:0] hw_int,
  output logic               in_handler,
  output logic [NUM_INT-1:0] int_pending,
  output logic [15:0]        exc_count
);

  typedef enum logic [1:0] {IDLE, RAISE, HANDLER, RETURN} state_t;

  state_t             state_q, state_d;
  logic [NUM_INT-1:0] sync_q [SYNC_STAGES];
  logic [NUM_INT-1:0] int_sync;
  logic [NUM_INT-1:0] int_req;
  logic [NUM_INT-1:0] int_grant;
  logic [NUM_INT-1:0] int_clr;
  logic               sync_cand;
  logic [4:0]         sync_cause;
  logic               raise_go;
  logic [4:0]         raise_cause;
  logic [4:0]         cause_q;
  logic [31:0]        exc_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign int_sync = sync_q[SYNC_STAGES-1];

  // Clearing the taken bit beats a same-cycle re-set of that bit; other bits set freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) int_pending <= '0;
    else        int_pending <= (int_pending | int_sync) & ~int_clr;
  end

  assign sync_cand = bus.teq_trap | bus.brk | bus.syscall;
  assign int_req   = int_pending & {NUM_INT{bus.status[0]}} & bus.status[11 +: NUM_INT];

  always_comb begin
    if (bus.teq_trap)      sync_cause = 5'b01101;
    else if (bus.brk)      sync_cause = 5'b01001;
    else if (bus.syscall)  sync_cause = 5'b01000;
    else                   sync_cause = 5'b00000;
  end

  // Descending scan so the lowest requesting line ends up granted.
  always_comb begin
    int_grant = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (int_req[i]) begin
        int_grant    = '0;
        int_grant[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    raise_go    = 1'b0;
    raise_cause = 5'b00000;
    int_clr     = '0;
    case (state_q)
      IDLE: begin
        if (sync_cand) begin
          state_d     = RAISE;
          raise_go    = 1'b1;
          raise_cause = sync_cause;
        end else if (|int_req) begin
          state_d     = RAISE;
          raise_go    = 1'b1;
          int_clr     = int_grant;
        end else if (bus.eret) begin
          state_d     = RETURN;
        end
      end
      HANDLER: begin
        if (sync_cand) begin
          state_d     = RAISE;
          raise_go    = 1'b1;
          raise_cause = sync_cause;
        end else if (bus.eret) begin
          state_d     = RETURN;
        end
      end
      RAISE:   state_d = HANDLER;
      RETURN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_q  <= 5'b00000;
      exc_pc_q <= 32'h0000_0000;
    end else if (raise_go) begin
      cause_q  <= raise_cause;
      exc_pc_q <= bus.pc_in;
    end
  end

`ifdef EXC_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        count_q <= 16'h0000;
    else if (raise_go) count_q <= count_q + 16'h0001;
  end

  assign exc_count = count_q;
`else
  assign exc_count = 16'h0000;
`endif

  // Pulses come straight from the state register, so they are glitch-free registered outputs.
  always_comb begin
    bus.exception   = (state_q == RAISE);
    bus.redirect    = (state_q == RAISE) || (state_q == RETURN);
    bus.cause       = cause_q;
    bus.exc_pc      = exc_pc_q;
    in_handler      = (state_q == HANDLER) || (state_q == RETURN);
    if (state_q == RAISE)       bus.redirect_pc = VECTOR;
    else if (state_q == RETURN) bus.redirect_pc = bus.epc;
    else                        bus.redirect_pc = 32'h0000_0000;
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: expected redirect pulses are queued at stimulus time and
// popped when the DUT pulses redirect; status checks use immediate assertions.
module tb_exc_ctrl;
  localparam logic [31:0] VEC = 32'h0040_0004;
  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] hw_int;
  logic          in_handler;
  logic [NI-1:0] int_pending;
  logic [15:0]   exc_count;

  exc_ctrl_if bus ();

  exc_ctrl #(.VECTOR(VEC), .NUM_INT(NI), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .hw_int      (hw_int),
    .in_handler  (in_handler),
    .int_pending (int_pending),
    .exc_count   (exc_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        exc;
    logic [4:0]  cause;
    logic [31:0] exc_pc;
    logic [31:0] rpc;
  } pulse_t;

  pulse_t sb[$];
  int vectors    = 0;
  int miscompares = 0;

`ifdef EXC_COUNT_EN
  localparam logic [31:0] EXP_COUNT6 = 32'd6;
`else
  localparam logic [31:0] EXP_COUNT6 = 32'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic e, input logic [4:0] c, input logic [31:0] p, input logic [31:0] r);
    pulse_t x;
    x.exc = e; x.cause = c; x.exc_pc = p; x.rpc = r;
    sb.push_back(x);
  endtask

  // Waits at most 'bound' cycles for a redirect pulse, then checks it against the queue head.
  task automatic wait_pulse(input string tag, input int bound);
    pulse_t p;
    int n = 0;
    while (!bus.redirect && n < bound) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, 32'(bus.redirect), 32'd1);
    if (bus.redirect) begin
      chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        p = sb.pop_front();
        chk({tag, "_exception"}, 32'(bus.exception), 32'(p.exc));
        chk({tag, "_cause"},     32'(bus.cause),     32'(p.cause));
        chk({tag, "_exc_pc"},    bus.exc_pc,         p.exc_pc);
        chk({tag, "_rpc"},       bus.redirect_pc,    p.rpc);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    hw_int = '0;
    bus.pc_in = 32'h0; bus.syscall = 1'b0; bus.brk = 1'b0; bus.teq_trap = 1'b0;
    bus.eret = 1'b0; bus.status = 32'h0; bus.epc = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_exception",   32'(bus.exception), 32'd0);
    chk("rst_redirect",    32'(bus.redirect),  32'd0);
    chk("rst_cause",       32'(bus.cause),     32'd0);
    chk("rst_exc_pc",      bus.exc_pc,         32'd0);
    chk("rst_rpc",         bus.redirect_pc,    32'd0);
    chk("rst_in_handler",  32'(in_handler),    32'd0);
    chk("rst_int_pending", 32'(int_pending),   32'd0);
    chk("rst_exc_count",   32'(exc_count),     32'd0);
    rst_n = 1'b1;
    tick();

    // syscall from IDLE
    bus.pc_in = 32'h0040_0020; bus.syscall = 1'b1;
    push(1'b1, 5'b01000, 32'h0040_0020, VEC);
    tick();
    bus.syscall = 1'b0;
    wait_pulse("syscall", 0);
    tick();
    chk("syscall_in_handler", 32'(in_handler), 32'd1);
    chk("syscall_single",     32'(bus.exception), 32'd0);

    // nested trap inside handler: all three together
    bus.pc_in = 32'h0040_0030;
    bus.teq_trap = 1'b1; bus.brk = 1'b1; bus.syscall = 1'b1;
    push(1'b1, 5'b01101, 32'h0040_0030, VEC);
    tick();
    bus.teq_trap = 1'b0; bus.brk = 1'b0; bus.syscall = 1'b0;
    wait_pulse("prio", 0);
    tick();
    chk("prio_single",     32'(bus.redirect), 32'd0);
    chk("prio_in_handler", 32'(in_handler),   32'd1);

    // eret back to EPC
    bus.epc = 32'h0040_0024; bus.eret = 1'b1;
    push(1'b0, 5'b01101, 32'h0040_0030, 32'h0040_0024);
    tick();
    bus.eret = 1'b0;
    wait_pulse("eret", 0);
    chk("eret_in_handler_ret", 32'(in_handler), 32'd1);
    tick();
    chk("eret_idle_in_handler", 32'(in_handler),   32'd0);
    chk("eret_idle_redirect",   32'(bus.redirect), 32'd0);

    // interrupt 0 enabled
    bus.status = 32'h0000_0801; bus.pc_in = 32'h0040_0040;
    hw_int = 4'b0001;
    tick();
    hw_int = '0;
    tick();
    chk("int_pend_early", 32'(int_pending), 32'd0);
    tick();
    chk("int_pend_set", 32'(int_pending), 32'd1);
    push(1'b1, 5'b00000, 32'h0040_0040, VEC);
    wait_pulse("int0", 1);
    chk("int_pend_clr", 32'(int_pending), 32'd0);
    tick();
    bus.eret = 1'b1;
    push(1'b0, 5'b00000, 32'h0040_0040, 32'h0040_0024);
    tick();
    bus.eret = 1'b0;
    wait_pulse("int0_ret", 0);
    tick();

    // interrupt with global enable off stays pending
    bus.status = 32'h0000_0800;
    hw_int = 4'b0001;
    tick();
    hw_int = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("masked_no_redirect", 32'(bus.redirect), 32'd0);
    end
    chk("masked_pending", 32'(int_pending), 32'd1);

    // pending interrupt held off while in handler
    bus.pc_in = 32'h0040_0060; bus.syscall = 1'b1;
    push(1'b1, 5'b01000, 32'h0040_0060, VEC);
    tick();
    bus.syscall = 1'b0;
    wait_pulse("sys2", 0);
    tick();
    bus.status = 32'h0000_0801;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("handler_block_redirect", 32'(bus.redirect), 32'd0);
    end
    chk("handler_block_pending", 32'(int_pending), 32'd1);
    bus.epc = 32'h0040_0064; bus.eret = 1'b1;
    push(1'b0, 5'b01000, 32'h0040_0060, 32'h0040_0064);
    push(1'b1, 5'b00000, 32'h0040_0060, VEC);
    tick();
    bus.eret = 1'b0;
    wait_pulse("sys2_ret", 0);
    tick();
    chk("ret_then_idle_redirect", 32'(bus.redirect), 32'd0);
    wait_pulse("late_int", 2);
    chk("late_int_pend_clr", 32'(int_pending), 32'd0);
    tick();

    // eret coincident with brk in handler: trap wins
    bus.pc_in = 32'h0040_0070; bus.brk = 1'b1; bus.eret = 1'b1;
    push(1'b1, 5'b01001, 32'h0040_0070, VEC);
    tick();
    bus.brk = 1'b0; bus.eret = 1'b0;
    wait_pulse("brk_eret", 0);
    tick();
    chk("brk_eret_no_return",  32'(bus.redirect), 32'd0);
    chk("brk_eret_in_handler", 32'(in_handler),   32'd1);
    tick();
    chk("brk_eret_quiet", 32'(bus.redirect), 32'd0);
    bus.eret = 1'b1;
    push(1'b0, 5'b01001, 32'h0040_0070, 32'h0040_0064);
    tick();
    bus.eret = 1'b0;
    wait_pulse("brk_ret", 0);
    tick();
    chk("exc_count_6", 32'(exc_count), EXP_COUNT6);
    chk("sb_drained",  32'(sb.size()), 32'd0);

    // reset asserted during RAISE
    bus.pc_in = 32'h0040_0080; bus.syscall = 1'b1;
    tick();
    bus.syscall = 1'b0;
    chk("mid_raise_exception", 32'(bus.exception), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_exception",  32'(bus.exception),  32'd0);
    chk("mid_rst_redirect",   32'(bus.redirect),   32'd0);
    chk("mid_rst_cause",      32'(bus.cause),      32'd0);
    chk("mid_rst_exc_pc",     bus.exc_pc,          32'd0);
    chk("mid_rst_rpc",        bus.redirect_pc,     32'd0);
    chk("mid_rst_in_handler", 32'(in_handler),     32'd0);
    chk("mid_rst_count",      32'(exc_count),      32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_redirect",   32'(bus.redirect), 32'd0);
    chk("post_rst_in_handler", 32'(in_handler),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
